keccak_round_sequencer: RTL and testbench

Control FSM for the Keccak-f[1600] round loop. It drives the sample, selector and round inputs of the 1600-bit state mux at the head of the round pipeline. It loads a fresh state from the absorb side, recirculates the pipeline output for rounds 1..ROUNDS-1, and flags completion. It also polices the loop for round-tag mismatches, lost feedback (timeout) and stray feedback. The block has no datapath: the 1600-bit state never passes through it.

---
 rtl/keccak_round_sequencer.sv | 141 ++++++++++++++
 tb/tb_keccak_round_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_sequencer.sv
// Round-loop sequencer for Keccak-f[1600]: steers the head-of-pipeline state mux,
// tracks the round tag of each issue and polices the loop for faults.
//
// state | meaning
// IDLE  | ready for a fresh state from the absorb side; feedback here is stray
// WAIT  | one permutation in flight; waiting for the pipeline to return round `rnd_exp`
module keccak_round_sequencer #(
    parameter int ROUNDS  = 24,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        fb_good,
    input  logic [5:0]  fb_round,
    output logic        mux_sample,
    output logic        mux_selector,
    output logic [4:0]  mux_round,
    output logic        out_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] done_count
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    localparam logic [1:0] CODE_MISMATCH = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CODE_STRAY    = 2'b11;

    logic        state, state_nxt;
    logic [4:0]  rnd_exp, rnd_exp_nxt;
    logic [9:0]  tmo, tmo_nxt;
    logic [1:0]  code_nxt;
    logic        done_inc;

    logic        ready_c, sample_c, sel_c, ov_c, err_c;
    logic [4:0]  round_c;

    logic        fb_match;
    logic        tmo_hit;

    // Bit 5 of the returned tag can never match a legal round, so it always counts as a mismatch.
    assign fb_match = fb_good && (fb_round == {1'b0, rnd_exp});
    assign tmo_hit  = (tmo == TMO_LAST);

    always_comb begin
        state_nxt   = state;
        rnd_exp_nxt = rnd_exp;
        tmo_nxt     = tmo;
        code_nxt    = err_code;
        done_inc    = 1'b0;
        ready_c     = 1'b0;
        sample_c    = 1'b0;
        sel_c       = 1'b0;
        round_c     = 5'd0;
        ov_c        = 1'b0;
        err_c       = 1'b0;

        case (state)
            ST_IDLE: begin
                ready_c  = 1'b1;
                sample_c = in_valid;
                if (fb_good) begin
                    err_c    = 1'b1;
                    code_nxt = CODE_STRAY;
                end
                if (in_valid) begin
                    rnd_exp_nxt = 5'd0;
                    tmo_nxt     = 10'd0;
                    state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fb_match) begin
                    if (rnd_exp < LAST_RND) begin
                        sample_c    = 1'b1;
                        sel_c       = 1'b1;
                        round_c     = rnd_exp + 5'd1;
                        rnd_exp_nxt = rnd_exp + 5'd1;
                        tmo_nxt     = 10'd0;
                    end else begin
                        ov_c      = 1'b1;
                        done_inc  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (fb_good) begin
                    err_c     = 1'b1;
                    code_nxt  = CODE_MISMATCH;
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    err_c     = 1'b1;
                    code_nxt  = CODE_TIMEOUT;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_nxt = tmo + 10'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // While reset is held the mux must not sample and no fault may be flagged.
    assign in_ready     = rst_n ? ready_c  : 1'b1;
    assign mux_sample   = rst_n ? sample_c : 1'b0;
    assign mux_selector = rst_n ? sel_c    : 1'b0;
    assign mux_round    = rst_n ? round_c  : 5'd0;
    assign out_valid    = rst_n ? ov_c     : 1'b0;
    assign err          = rst_n ? err_c    : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rnd_exp    <= 5'd0;
            tmo        <= 10'd0;
            err_code   <= 2'b00;
            busy       <= 1'b0;
            done_count <= 16'd0;
        end else begin
            state    <= state_nxt;
            rnd_exp  <= rnd_exp_nxt;
            tmo      <= tmo_nxt;
            busy     <= (state_nxt == ST_WAIT);
            if (err_c) begin
                err_code <= code_nxt;
            end
            if (done_inc) begin
                done_count <= done_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Randomized bench for keccak_round_sequencer: a model pipeline returns each issue after L
// cycles, and expected issue/completion/fault edges are computed from ROUNDS, L and TIMEOUT.
module tb_keccak_round_sequencer;

    localparam int ROUNDS = 24;
    localparam int TMO    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        fb_good;
    logic [5:0]  fb_round;
    logic        mux_sample;
    logic        mux_selector;
    logic [4:0]  mux_round;
    logic        out_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] done_count;

    keccak_round_sequencer #(.ROUNDS(ROUNDS), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fb_good      (fb_good),
        .fb_round     (fb_round),
        .mux_sample   (mux_sample),
        .mux_selector (mux_selector),
        .mux_round    (mux_round),
        .out_valid    (out_valid),
        .err          (err),
        .err_code     (err_code),
        .busy         (busy),
        .done_count   (done_count)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int edge_n = 0;

    // model pipeline: at most one tagged state in flight
    int        lat = 3;
    int        corrupt = -1;
    int        withhold = -1;
    logic [5:0] corrupt_tag = 6'd0;
    bit        pend = 1'b0;
    int        pend_edge = 0;
    int        pend_round = 0;

    int s_sample, s_sel, s_round, s_ov, s_err, s_ready, s_busy;

    int exp_code = 0;
    int exp_done = 0;
    int last_load = 0;
    int last_ev = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: sample at the falling edge, then present next-cycle feedback #1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_sample = int'(mux_sample);
        s_sel    = int'(mux_selector);
        s_round  = int'(mux_round);
        s_ov     = int'(out_valid);
        s_err    = int'(err);
        s_ready  = int'(in_ready);
        s_busy   = int'(busy);
        if (mux_sample && !(withhold >= 0 && int'(mux_round) == withhold)) begin
            pend       = 1'b1;
            pend_edge  = edge_n + 1 + lat;
            pend_round = int'(mux_round);
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (pend && pend_edge == edge_n + 1) begin
            fb_good  = 1'b1;
            fb_round = (pend_round == corrupt) ? corrupt_tag : 6'(pend_round);
            pend     = 1'b0;
        end else begin
            fb_good  = 1'b0;
            fb_round = 6'($urandom);
        end
    endtask

    // kind: 0 nominal, 1 wrong tag returned for round frnd, 2 feedback for round frnd withheld
    task automatic run_perm(input int l, input int kind, input int frnd, input int tag,
                            input bit hold, input bit stray);
        int load_e, ev_e, k, ev, got_ov, got_err, issue_bad, busy_bad, budget, dexp;
        lat      = l;
        corrupt  = (kind == 1) ? frnd : -1;
        withhold = (kind == 2) ? frnd : -1;
        if (tag >= 0)
            corrupt_tag = 6'(tag);
        else if ($urandom_range(1, 0) == 1)
            corrupt_tag = 6'(frnd) | 6'h20;
        else
            corrupt_tag = 6'((frnd + int'($urandom_range(31, 1))) % 32);

        in_valid = 1'b1;
        if (stray) begin
            fb_good  = 1'b1;
            fb_round = 6'($urandom);
        end
        tick();
        load_e = edge_n;
        chk("load_ready", s_ready, 1);
        chk("load_sample", s_sample, 1);
        chk("load_selector", s_sel, 0);
        chk("load_round", s_round, 0);
        chk("load_busy", s_busy, 0);
        chk("load_err", s_err, int'(stray));
        if (stray) begin
            exp_code = 3;
            chk("stray_load_code", int'(err_code), exp_code);
        end
        if (!hold) in_valid = 1'b0;

        k = 1; ev = 0; ev_e = 0; got_ov = 0; got_err = 0; issue_bad = 0; busy_bad = 0;
        budget = ROUNDS * l + TMO + 8;
        for (int c = 0; c < budget && ev == 0; c++) begin
            tick();
            if (s_busy != 1) busy_bad++;
            if (s_sample == 1) begin
                if (edge_n != load_e + k * l || s_sel != 1 || s_round != k) issue_bad++;
                k++;
            end
            if (s_ov == 1 || s_err == 1) begin
                ev = 1; ev_e = edge_n; got_ov = s_ov; got_err = s_err;
                chk("event_no_sample", s_sample, 0);
            end
        end
        if (ev == 0) chk("event_within_budget", 0, 1);

        if (kind == 0)      dexp = ROUNDS * l;
        else if (kind == 1) dexp = (frnd + 1) * l;
        else                dexp = frnd * l + TMO;
        chk("issue_timing", issue_bad, 0);
        chk("busy_in_flight", busy_bad, 0);
        chk("issue_count", k, (kind == 0) ? ROUNDS : frnd + 1);
        chk("out_valid_seen", got_ov, int'(kind == 0));
        chk("err_seen", got_err, int'(kind != 0));
        chk("event_latency", ev_e - load_e, dexp);

        if (kind == 0) exp_done = (exp_done + 1) % 65536;
        if (kind == 1) exp_code = 1;
        if (kind == 2) exp_code = 2;
        chk("done_count", int'(done_count), exp_done);
        chk("err_code", int'(err_code), exp_code);
        last_load = load_e;
        last_ev   = ev_e;

        if (!hold) begin
            tick();
            chk("after_ready", s_ready, 1);
            chk("after_busy", s_busy, 0);
            chk("after_sample", s_sample, 0);
            chk("after_err", s_err, 0);
        end
    endtask

    task automatic run_reset(input int l);
        int found, re, nerr, eedge, samp;
        lat = l; corrupt = -1; withhold = -1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        found = 0;
        for (int c = 0; c < ROUNDS * l + 8 && found == 0; c++) begin
            tick();
            if (s_sample == 1 && s_round == 12) found = 1;
        end
        chk("reset_reached_round12", found, 1);
        re = edge_n;
        rst_n = 1'b0;
        tick();
        exp_code = 0;
        exp_done = 0;
        chk("rst_sample", s_sample, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", s_busy, 0);
        chk("rst_out_valid", s_ov, 0);
        chk("rst_err", s_err, 0);
        chk("rst_err_code", int'(err_code), exp_code);
        chk("rst_done_count", int'(done_count), exp_done);
        rst_n = 1'b1;
        nerr = 0; eedge = 0; samp = 0;
        for (int c = 0; c < l + 4; c++) begin
            tick();
            if (s_err == 1) begin nerr++; eedge = edge_n; end
            if (s_sample == 1) samp++;
        end
        exp_code = 3;
        chk("stray_count", nerr, 1);
        chk("stray_edge", eedge - re, l);
        chk("stray_no_issue", samp, 0);
        chk("stray_code", int'(err_code), exp_code);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_ev, kind, l, frnd;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        fb_good  = 1'b1;
        fb_round = 6'd0;
        @(negedge clk);
        chk("reset_sample", int'(mux_sample), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err_code", int'(err_code), 0);
        chk("reset_done_count", int'(done_count), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        fb_good  = 1'b0;

        run_perm(3, 0, 0, -1, 1'b0, 1'b0);

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prev_ev = last_ev;
            run_perm(int'($urandom_range(6, 2)), 0, 0, -1, 1'b1, 1'b0);
            if (i > 0) chk("b2b_load_edge", last_load, prev_ev + 1);
        end
        in_valid = 1'b0;
        tick();

        run_perm(3, 1, 5, 7, 1'b0, 1'b0);
        run_perm(int'($urandom_range(6, 2)), 2, 10, -1, 1'b0, 1'b0);
        run_reset(3);
        run_perm(3, 0, 0, -1, 1'b0, 1'b0);
        run_perm(3, 0, 0, -1, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            kind = int'($urandom_range(2, 0));
            l    = int'($urandom_range(6, 2));
            frnd = int'($urandom_range(ROUNDS - 1, 0));
            run_perm(l, kind, frnd, -1, 1'b0, 1'b0);
            repeat (int'($urandom_range(3, 0))) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
